// File: rtl/wb_copy_master.sv
// Wishbone B3 classic-cycle block copier: each 32-bit word is copied with one read and then one write.
// Optional ack watchdog is enabled by defining WB_COPY_TIMEOUT_EN.
module wb_copy_master #(
  parameter int AW      = 32,
  parameter int LW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [LW-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic [1:0]    dbg_state
);

  // Bus handshake: a beat is offered while cyc&stb are high, with adr/dat/we held
  // stable. The beat completes on the first rising edge that samples ack or err.
  // When err and ack are both high on that edge, err takes priority.
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t        state, state_n;
  logic [AW-1:0] src_q, dst_q, src_n, dst_n, adr_n;
  logic [AW-1:0] src_al, dst_al;
  logic [LW-1:0] len_q, len_n;
  logic [31:0]   dat_n;
  logic          cyc_n, stb_n, we_n, busy_n, done_n, err_n;
  logic          bus_err;

  assign src_al    = {src_i[AW-1:2], 2'b00};
  assign dst_al    = {dst_i[AW-1:2], 2'b00};
  assign wb_sel_o  = 4'hf;
  assign wb_cti_o  = 3'b000;
  assign wb_bte_o  = 2'b00;
  assign dbg_state = state;

`ifdef WB_COPY_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  logic [7:0] wd_q;

  // The watchdog restarts whenever stb is low, so each new strobe starts again from zero.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !wb_stb_o || wb_ack_i || wb_err_i) wd_q <= '0;
    else                                               wd_q <= wd_q + 8'd1;
  end

  assign bus_err = wb_err_i || (wd_q == TO_LIMIT);
`else
  localparam int timeout_unused = TIMEOUT;
  assign bus_err = wb_err_i;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_n;
      src_q    <= src_n;
      dst_q    <= dst_n;
      len_q    <= len_n;
      wb_adr_o <= adr_n;
      wb_dat_o <= dat_n;
      wb_we_o  <= we_n;
      wb_cyc_o <= cyc_n;
      wb_stb_o <= stb_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      err_o    <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    src_n   = src_q;
    dst_n   = dst_q;
    len_n   = len_q;
    adr_n   = wb_adr_o;
    dat_n   = wb_dat_o;
    we_n    = wb_we_o;
    cyc_n   = wb_cyc_o;
    stb_n   = wb_stb_o;
    busy_n  = busy_o;
    done_n  = 1'b0;
    err_n   = err_o;

    case (state)
      IDLE: begin
        if (start_i) begin
          src_n  = src_al;
          dst_n  = dst_al;
          len_n  = len_i;
          err_n  = 1'b0;
          busy_n = 1'b1;
          if (len_i != '0) begin
            state_n = RD;
            cyc_n   = 1'b1;
            stb_n   = 1'b1;
            we_n    = 1'b0;
            adr_n   = src_al;
          end else begin
            state_n = FIN;
          end
        end
      end

      RD: begin
        if (wb_stb_o) begin
          if (bus_err) begin
            err_n   = 1'b1;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
            state_n = FIN;
          end else if (wb_ack_i) begin
            dat_n   = wb_dat_i;
            stb_n   = 1'b0;
            state_n = WR;
          end
        end else begin
          // Arrive here with stb low after the previous write completed; this is the one-cycle gap.
          stb_n = 1'b1;
          we_n  = 1'b0;
          adr_n = src_q;
        end
      end

      WR: begin
        if (wb_stb_o) begin
          if (bus_err) begin
            err_n   = 1'b1;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            we_n    = 1'b0;
            state_n = FIN;
          end else if (wb_ack_i) begin
            src_n = src_q + AW'(4);
            dst_n = dst_q + AW'(4);
            len_n = len_q - LW'(1);
            stb_n = 1'b0;
            if (len_q == LW'(1)) begin
              cyc_n   = 1'b0;
              we_n    = 1'b0;
              state_n = FIN;
            end else begin
              state_n = RD;
            end
          end
        end else begin
          stb_n = 1'b1;
          we_n  = 1'b1;
          adr_n = dst_q;
        end
      end

      FIN: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Directed bench for wb_copy_master. The slave is a RAM that acks combinationally after a
// configurable number of wait states, and it can be told to return an error or to never respond.
module tb_wb_copy_master;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        start_i;
  logic [31:0] src_i, dst_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        s_ack, s_err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_copy_master #(.AW(32), .LW(16), .TIMEOUT(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (wb_rst_i),
    .start_i  (start_i),
    .src_i    (src_i),
    .dst_i    (dst_i),
    .len_i    (len_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_cti_o (wb_cti_o),
    .wb_bte_o (wb_bte_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (s_ack),
    .wb_err_i (s_err),
    .dbg_state(dbg_state)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [0:255];
  int waits    = 0;
  int err_wr_n = 0;
  int wcnt     = 0;
  int wr_seen  = 0;
  bit hang     = 1'b0;

  always_comb begin
    s_ack = 1'b0;
    s_err = 1'b0;
    if (wb_cyc_o && wb_stb_o && !hang && wcnt == waits) begin
      if (wb_we_o && err_wr_n != 0 && wr_seen == err_wr_n - 1) s_err = 1'b1;
      else                                                     s_ack = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!wb_cyc_o) wr_seen <= 0;
    else if (wb_stb_o && wb_we_o && (s_ack || s_err)) wr_seen <= wr_seen + 1;
    if (wb_stb_o && !(s_ack || s_err)) wcnt <= wcnt + 1;
    else                               wcnt <= 0;
    if (wb_cyc_o && wb_stb_o && wb_we_o && s_ack) mem[wb_adr_o[9:2]] = wb_dat_o;
  end

  assign wb_dat_i = mem[wb_adr_o[9:2]];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  int busy_cnt, done_cyc, done_cnt, last_wack, cyc_cnt, stab_viol, cyc_after_err;
  logic first_cyc, first_stb, first_we, first_err;
  logic [31:0] first_adr;

  task automatic do_reset();
    @(negedge clk);
    wb_rst_i = 1'b1;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
  endtask

  // n counts negedges after the edge that accepts start; n=1 is the first cycle after acceptance.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input int max_cyc);
    logic        prev_wait, prev_err, p_we;
    logic [31:0] p_adr, p_dat;
    @(negedge clk);
    start_i = 1'b1; src_i = s; dst_i = d; len_i = l;
    busy_cnt = 0; done_cyc = 0; done_cnt = 0; last_wack = 0; cyc_cnt = 0;
    stab_viol = 0; cyc_after_err = -1;
    prev_wait = 1'b0; prev_err = 1'b0; p_we = 1'b0; p_adr = '0; p_dat = '0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (n == 1) begin
        first_cyc = wb_cyc_o; first_stb = wb_stb_o; first_we = wb_we_o;
        first_adr = wb_adr_o; first_err = err_o;
      end
      if (busy_o) busy_cnt++;
      if (wb_cyc_o) cyc_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = n;
      end
      if (prev_err) cyc_after_err = int'(wb_cyc_o);
      if (prev_wait && wb_stb_o &&
          (wb_adr_o !== p_adr || wb_dat_o !== p_dat || wb_we_o !== p_we)) stab_viol++;
      if (wb_cyc_o && wb_stb_o && wb_we_o && s_ack) last_wack = n;
      prev_err  = wb_cyc_o && wb_stb_o && s_err;
      prev_wait = wb_stb_o && !s_ack && !s_err;
      p_adr = wb_adr_o; p_dat = wb_dat_o; p_we = wb_we_o;
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    do_reset();

    // reset state
    @(negedge clk);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cyc_stb_we", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
    check("rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'h0);
    check("rst_state", dbg_state, 2'd0);

    // 1: four-word copy, zero-wait slave: 4 cycles per word
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    run_copy(32'h0, 32'h100, 16'd4, 24);
    check("t1_first_beat", {first_cyc, first_stb, first_we}, 3'b110);
    check("t1_first_adr", first_adr, 32'h0);
    check("t1_w0", mem[64], 32'd11);
    check("t1_w1", mem[65], 32'd22);
    check("t1_w2", mem[66], 32'd33);
    check("t1_w3", mem[67], 32'd44);
    check("t1_last_wack", last_wack, 15);
    check("t1_busy_cycles", busy_cnt, 16);
    check("t1_done_cycle", done_cyc, 17);
    check("t1_done_count", done_cnt, 1);
    check("t1_err", err_o, 0);
    check("t1_fixed_sigs", {wb_sel_o, wb_cti_o, wb_bte_o}, {4'hf, 3'b000, 2'b00});

    // 3: error on the second write of a three-word copy
    mem[16] = 32'ha1; mem[17] = 32'ha2; mem[18] = 32'ha3;
    err_wr_n = 2;
    run_copy(32'h40, 32'h180, 16'd3, 14);
    err_wr_n = 0;
    check("t3_word0", mem[96], 32'ha1);
    check("t3_word1_untouched", mem[97], 32'h0);
    check("t3_err", err_o, 1);
    check("t3_cyc_after_err", cyc_after_err, 0);
    check("t3_done_cycle", done_cyc, 9);
    check("t3_done_count", done_cnt, 1);

    // 2: zero length, which also clears the sticky error from the previous copy
    run_copy(32'h0, 32'h300, 16'd0, 8);
    check("t2_err_cleared", first_err, 0);
    check("t2_no_cyc", cyc_cnt, 0);
    check("t2_done_cycle", done_cyc, 2);
    check("t2_done_count", done_cnt, 1);

    // 4: three wait states, so each word takes 10 cycles
    mem[32] = 32'h1234_5678; mem[33] = 32'h9abc_def0;
    waits = 3;
    run_copy(32'h80, 32'h1c0, 16'd2, 30);
    waits = 0;
    check("t4_first_adr", first_adr, 32'h80);
    check("t4_w0", mem[112], 32'h1234_5678);
    check("t4_w1", mem[113], 32'h9abc_def0);
    check("t4_stable", stab_viol, 0);
    check("t4_last_wack", last_wack, 19);
    check("t4_busy_cycles", busy_cnt, 20);
    check("t4_done_cycle", done_cyc, 21);

    // 5: reset asserted in the cycle after the first read ack
    mem[128] = 32'hdead_beef;
    @(negedge clk);
    start_i = 1'b1; src_i = 32'h0; dst_i = 32'h200; len_i = 16'd4;
    @(negedge clk);
    start_i = 1'b0;
    check("t5_read_ack", {s_ack, wb_we_o}, 2'b10);
    @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    check("t5_bus_released", {wb_cyc_o, wb_stb_o, busy_o}, 3'b000);
    done_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (done_o) done_cnt++;
      @(negedge clk);
    end
    check("t5_no_done", done_cnt, 0);
    check("t5_dst_untouched", mem[128], 32'hdead_beef);

    // 6: slave never responds
    hang = 1'b1;
    @(negedge clk);
    start_i = 1'b1; src_i = 32'h0; dst_i = 32'h300; len_i = 16'd1;
`ifdef WB_COPY_TIMEOUT_EN
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (n == 17) check("t6_cyc_before_timeout", wb_cyc_o, 1);
      if (n == 18) begin
        check("t6_cyc_after_timeout", wb_cyc_o, 0);
        check("t6_err", err_o, 1);
      end
    end
`else
    for (int n = 1; n <= 1000; n++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    check("t6_stb_held", {wb_cyc_o, wb_stb_o}, 2'b11);
    check("t6_still_busy", busy_o, 1);
`endif
    hang = 1'b0;
    do_reset();
    @(negedge clk);
    check("t6_idle_after_reset", {busy_o, wb_cyc_o, wb_stb_o}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
